pipe_stall_ctrl: RTL

//   Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//   - Arbitrates four hazard sources: load-use, taken branch (resolved in MEM),

---
 rtl/pipe_stall_ctrl_pkg.sv | 23 ++
 rtl/pipe_stall_ctrl_perf_cnt.sv | 20 ++
 rtl/pipe_stall_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding,
// the zero-register index, default parameter values and the load-use hazard test.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int unsigned MDU_LAT_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT   = 32;

  // A load whose destination is read by the instruction right behind it; r0 never hazards.
  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating event counter with synchronous clear, used for stall/flush statistics.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  // Holds at all-ones instead of wrapping so a long run never reads as a small count.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (RUN / MDU_BUSY / MEM_WAIT).
// Optional performance counters are built when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       if_id_rs_i,
  input  logic [4:0]       if_id_rt_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic             id_ex_memread_i,
  input  logic             branch_taken_i,
  input  logic             mdu_start_i,
  input  logic             dmem_wait_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_write_o,
`ifdef PIPE_STALL_PERF_EN
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`else
  output logic             mdu_busy_o
`endif
);

  localparam logic [7:0] MDU_LAT_M1 = 8'(MDU_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  state_t     eff_state;
  logic [7:0] mdu_cnt_q;
  logic [7:0] mdu_cnt_d;
  logic       load_use;
  logic       branch_flush;

  assign load_use     = load_use_hit(id_ex_memread_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i);
  assign branch_flush = !rst_i && !dmem_wait_i && branch_taken_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      mdu_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // The cycle leaving MEM_WAIT already behaves as the state it returns to.
  always_comb begin
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = (mdu_cnt_q != 8'd0) ? ST_MDU_BUSY : ST_RUN;
    end
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    if (dmem_wait_i) begin
      state_d = ST_MEM_WAIT;
    end else if (branch_taken_i) begin
      state_d   = ST_RUN;
      mdu_cnt_d = 8'd0;
    end else if (eff_state == ST_MDU_BUSY) begin
      mdu_cnt_d = mdu_cnt_q - 8'd1;
      state_d   = (mdu_cnt_q == 8'd1) ? ST_RUN : ST_MDU_BUSY;
    end else if (mdu_start_i) begin
      mdu_cnt_d = MDU_LAT_M1;
      state_d   = ST_MDU_BUSY;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    ex_mem_write_o = 1'b1;
    mem_wb_write_o = 1'b1;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      ex_mem_write_o = 1'b0;
      mem_wb_write_o = 1'b0;
    end else if (dmem_wait_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      ex_mem_write_o = 1'b0;
      mem_wb_write_o = 1'b0;
    end else if (branch_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (eff_state == ST_MDU_BUSY) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      ex_mem_flush_o = 1'b1;
    end else if (!mdu_start_i && load_use) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  assign mdu_busy_o = !rst_i && (state_q == ST_MDU_BUSY);

`ifdef PIPE_STALL_PERF_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (!rst_i && !pc_write_o),
    .count_o (stall_cnt_o)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (branch_flush),
    .count_o (flush_cnt_o)
  );
`else
  logic unused_branch_flush;
  assign unused_branch_flush = branch_flush;
`endif

endmodule
